// File: rtl/m_sync_fifo_pkg.sv
// m_sync_fifo_pkg: shared defaults, sticky-flag bit positions and transfer-kind encoding for the FIFO library
package m_sync_fifo_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int STICKY_W = 2;
   localparam int OVF_BIT = 0;
   localparam int UDF_BIT = 1;
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } op_e;
endpackage

// File: rtl/m_ff.sv
// m_ff: enabled D register with optional asynchronous active-low reset
module m_ff #(
   parameter int WIDTH = 1,
   parameter bit RST_N_EN = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   if (RST_N_EN) begin : g_rst
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) q <= RESET_VAL;
         else if (en) q <= d;
   end else begin : g_nrst
      logic unused_rst_n;
      assign unused_rst_n = rst_n;
      always_ff @(posedge clk)
         if (en) q <= d;
   end
endmodule

// File: rtl/m_fifo_ptr.sv
// m_fifo_ptr: pointer over 0..DEPTH-1 that wraps by explicit compare, so DEPTH need not be a power of two
module m_fifo_ptr #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);
   logic [PTR_W-1:0] ptr_d;
   assign ptr_d = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   m_ff #(.WIDTH(PTR_W), .RST_N_EN(1'b1), .RESET_VAL('0)) u_ptr (
      .clk(clk), .rst_n(rst_n), .en(inc), .d(ptr_d), .q(ptr)
   );
endmodule

// File: rtl/m_sync_fifo.sv
// m_sync_fifo: single-clock first-word-fall-through FIFO built from m_ff storage, pointers, count and sticky error flags
module m_sync_fifo
   import m_sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_d;
   logic [STICKY_W-1:0] sticky, sticky_set;
   logic [WIDTH-1:0] mem [DEPTH];
   logic push_ok, pop_ok;
   op_e op;
   // Acceptance looks only at registered flags, never at the partner request.
   assign full = count == CNT_W'(DEPTH);
   assign empty = count == '0;
   assign push_ok = push & ~full;
   assign pop_ok = pop & ~empty;
   assign op = op_e'({push_ok, pop_ok});
   assign count_d = (op == OP_PUSH) ? count + 1'b1 : count - 1'b1;
   always_comb begin
      sticky_set = '0;
      sticky_set[OVF_BIT] = push & full;
      sticky_set[UDF_BIT] = pop & empty;
   end
   m_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .rst_n(rst_n), .inc(push_ok), .ptr(wr_ptr));
   m_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .rst_n(rst_n), .inc(pop_ok), .ptr(rd_ptr));
   m_ff #(.WIDTH(CNT_W), .RST_N_EN(1'b1), .RESET_VAL('0)) u_count (
      .clk(clk), .rst_n(rst_n), .en(push_ok ^ pop_ok), .d(count_d), .q(count)
   );
   m_ff #(.WIDTH(STICKY_W), .RST_N_EN(1'b1), .RESET_VAL('0)) u_sticky (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .d(sticky | sticky_set), .q(sticky)
   );
   assign overflow = sticky[OVF_BIT];
   assign underflow = sticky[UDF_BIT];
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      m_ff #(.WIDTH(WIDTH), .RST_N_EN(1'b0)) u_ent (
         .clk(clk), .rst_n(rst_n), .en(push_ok && wr_ptr == PTR_W'(i)), .d(push_data), .q(mem[i])
      );
   end
   assign pop_data = mem[rd_ptr];
   a_known_req: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({push, pop}));
endmodule
